// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared TDM link types and sizing for the tx and rx sides
package tdm_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_e;

    localparam int TDM_N_DEFAULT = 8;
    localparam int TDM_W_DEFAULT = 1;

    // Wide enough to hold slot N, the parity slot in TDM_PARITY_EN builds.
    function automatic int tdm_slot_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// rtl/tdm_slot_counter.sv - wrapping slot counter with clear and load-to-1 (resync)
module tdm_slot_counter #(
    parameter int WIDTH = 4,
    parameter int LAST  = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_load1,
    output logic [WIDTH-1:0] o_count,
    output logic             o_last
);

    logic [WIDTH-1:0] r_count;
    logic             w_last;

    assign w_last = (r_count == WIDTH'(LAST));

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_count <= '0;
        end else if (i_load1) begin
            r_count <= WIDTH'(1);
        end else if (i_en) begin
            r_count <= w_last ? '0 : r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_last  = w_last;

endmodule

// File: rtl/tdm_demux_rx.sv
// rtl/tdm_demux_rx.sv - TDM link receiver: slot tracking, 1:N demux, frame publish (TDM_PARITY_EN adds a parity slot)
module tdm_demux_rx
    import tdm_pkg::*;
#(
    parameter int N = TDM_N_DEFAULT,
    parameter int W = TDM_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_i,
    input  logic                 sync_i,
    input  logic [W-1:0]         data_i,
    output logic [N*W-1:0]       ch_o,
    output logic                 frame_valid_o,
    output logic                 lock_o,
    output logic [$clog2(N)-1:0] slot_o,
    output logic                 err_o
);

    localparam int SW = tdm_slot_width(N);
`ifdef TDM_PARITY_EN
    localparam int LAST = N;
`else
    localparam int LAST = N - 1;
`endif

    tdm_state_e     r_state;
    tdm_state_e     w_state_nxt;
    logic [N*W-1:0] r_shadow;
    logic [N*W-1:0] r_ch;
    logic [N*W-1:0] w_pub_data;
    logic           r_fv;
    logic           r_err;
    logic           w_pub;
    logic           w_err;
    logic           w_wr;
    logic           w_en;
    logic           w_clr;
    logic           w_load1;
    logic [SW-1:0]  w_slot;
    logic           w_last;
    logic           w_slot0;
    int             w_idx;

    tdm_slot_counter #(.WIDTH(SW), .LAST(LAST)) u_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_en),
        .i_clr   (w_clr),
        .i_load1 (w_load1),
        .o_count (w_slot),
        .o_last  (w_last)
    );

    assign w_slot0 = (w_slot == '0);

`ifdef TDM_PARITY_EN
    assign w_pub_data = r_shadow;
`else
    assign w_pub_data = {data_i, r_shadow[(N-1)*W-1:0]};
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pub       = 1'b0;
        w_err       = 1'b0;
        w_wr        = 1'b0;
        w_en        = 1'b0;
        w_clr       = 1'b0;
        w_load1     = 1'b0;
        if (valid_i) begin
            case (r_state)
                HUNT: begin
                    if (sync_i) begin
                        w_wr        = 1'b1;
                        w_load1     = 1'b1;
                        w_state_nxt = LOCKED;
                    end
                end
                LOCKED: begin
                    if (sync_i && !w_slot0) begin
                        // Early sync: restart the frame on this sample.
                        w_err   = 1'b1;
                        w_wr    = 1'b1;
                        w_load1 = 1'b1;
                    end else if (!sync_i && w_slot0) begin
                        w_err       = 1'b1;
                        w_clr       = 1'b1;
                        w_state_nxt = HUNT;
                    end else begin
                        w_en = 1'b1;
`ifdef TDM_PARITY_EN
                        w_wr = !w_last;
                        if (w_last) begin
                            if ((^r_shadow) == data_i[0]) begin
                                w_pub = 1'b1;
                            end else begin
                                w_err = 1'b1;
                            end
                        end
`else
                        w_wr  = 1'b1;
                        w_pub = w_last;
`endif
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end
        w_idx = w_load1 ? 0 : int'(w_slot);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= HUNT;
            r_shadow <= '0;
            r_ch     <= '0;
            r_fv     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_fv    <= w_pub;
            r_err   <= w_err;
            if (w_wr) begin
                r_shadow[w_idx*W +: W] <= data_i;
            end
            if (w_pub) begin
                r_ch <= w_pub_data;
            end
        end
    end

    assign ch_o          = r_ch;
    assign frame_valid_o = r_fv;
    assign err_o         = r_err;
    assign lock_o        = (r_state == LOCKED);
    assign slot_o        = w_slot[$clog2(N)-1:0];

endmodule

// File: tb/tb_tdm_demux_rx.sv
// tb/tb_tdm_demux_rx.sv - directed vector bench for tdm_demux_rx (N=8, W=1)
module tb_tdm_demux_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_i;
    logic       sync_i;
    logic [0:0] data_i;
    logic [7:0] ch_o;
    logic       frame_valid_o;
    logic       lock_o;
    logic [2:0] slot_o;
    logic       err_o;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic       rst;
        logic       v;
        logic       s;
        logic       d;
        logic [7:0] ch;
        logic       fv;
        logic       lk;
        logic [2:0] sl;
        logic       er;
    } vec_t;

    vec_t tab_a[$];
    vec_t tab_b[$];

    always #5 clk = ~clk;

    tdm_demux_rx #(.N(8), .W(1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_i       (valid_i),
        .sync_i        (sync_i),
        .data_i        (data_i),
        .ch_o          (ch_o),
        .frame_valid_o (frame_valid_o),
        .lock_o        (lock_o),
        .slot_o        (slot_o),
        .err_o         (err_o)
    );

    function automatic vec_t mk(input logic r, v, s, d, input logic [7:0] ch,
                                input logic fv, lk, input logic [2:0] sl, input logic er);
        vec_t t;
        t.rst = r; t.v = v; t.s = s; t.d = d;
        t.ch = ch; t.fv = fv; t.lk = lk; t.sl = sl; t.er = er;
        return t;
    endfunction

    task automatic step(input vec_t t, input string tag);
        rst_n   = t.rst;
        valid_i = t.v;
        sync_i  = t.s;
        data_i  = t.d;
        @(posedge clk);
        #1;
        n_vec++;
        if (ch_o !== t.ch || frame_valid_o !== t.fv || lock_o !== t.lk ||
            slot_o !== t.sl || err_o !== t.er) begin
            n_bad++;
            $display("FAIL %s #%0d: got ch=%h fv=%b lock=%b slot=%0d err=%b, want ch=%h fv=%b lock=%b slot=%0d err=%b",
                     tag, n_vec, ch_o, frame_valid_o, lock_o, slot_o, err_o,
                     t.ch, t.fv, t.lk, t.sl, t.er);
        end
    endtask

    initial begin
        logic [7:0] f4d;
        logic [7:0] f0f;
        logic [7:0] fa5;
        f4d = 8'h4D;
        f0f = 8'h0F;
        fa5 = 8'hA5;
        rst_n = 1'b0; valid_i = 1'b0; sync_i = 1'b0; data_i = 1'b0;

`ifdef TDM_PARITY_EN
        tab_a.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++)
            tab_a.push_back(mk(1, 1, i == 0, f4d[i], 8'h00, 0, 1, 3'((i + 1) % 9), 0));
        tab_a.push_back(mk(1, 1, 0, 0, 8'h4D, 1, 1, 0, 0));
        for (int i = 0; i < 8; i++)
            tab_a.push_back(mk(1, 1, i == 0, f4d[i], 8'h4D, 0, 1, 3'((i + 1) % 9), 0));
        tab_a.push_back(mk(1, 1, 0, 1, 8'h4D, 0, 1, 0, 1));
        for (int i = 0; i < 8; i++)
            tab_a.push_back(mk(1, 1, i == 0, fa5[i], 8'h4D, 0, 1, 3'((i + 1) % 9), 0));
        tab_a.push_back(mk(1, 1, 0, 0, 8'hA5, 1, 1, 0, 0));
        foreach (tab_a[k]) step(tab_a[k], "par");
`else
        // Reset, a dropped unsynced beat in HUNT, then the 8'h4D frame.
        tab_a.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0, 0));
        tab_a.push_back(mk(1, 0, 0, 0, 8'h00, 0, 0, 0, 0));
        tab_a.push_back(mk(1, 1, 0, 1, 8'h00, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++)
            tab_a.push_back(mk(1, 1, i == 0, f4d[i], (i == 7) ? 8'h4D : 8'h00,
                               i == 7, 1, 3'((i + 1) % 8), 0));
        tab_a.push_back(mk(1, 0, 0, 0, 8'h4D, 0, 1, 0, 0));

        // 8'hFF, partial frame, early sync at slot 4, then 8'h0F from the resync point.
        for (int i = 0; i < 8; i++)
            tab_b.push_back(mk(1, 1, i == 0, 1, (i == 7) ? 8'hFF : 8'h4D,
                               i == 7, 1, 3'((i + 1) % 8), 0));
        for (int i = 0; i < 4; i++)
            tab_b.push_back(mk(1, 1, i == 0, 0, 8'hFF, 0, 1, 3'(i + 1), 0));
        tab_b.push_back(mk(1, 1, 1, 1, 8'hFF, 0, 1, 1, 1));
        for (int i = 1; i < 8; i++)
            tab_b.push_back(mk(1, 1, 0, f0f[i], (i == 7) ? 8'h0F : 8'hFF,
                               i == 7, 1, 3'((i + 1) % 8), 0));
        // Missing sync drops lock, unsynced beats ignored, relock, reset at slot 5.
        tab_b.push_back(mk(1, 1, 0, 1, 8'h0F, 0, 0, 0, 1));
        tab_b.push_back(mk(1, 1, 0, 1, 8'h0F, 0, 0, 0, 0));
        tab_b.push_back(mk(1, 1, 0, 0, 8'h0F, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            tab_b.push_back(mk(1, 1, i == 0, fa5[i], 8'h0F, 0, 1, 3'(i + 1), 0));
        tab_b.push_back(mk(0, 1, 0, 1, 8'h00, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++)
            tab_b.push_back(mk(1, 1, i == 0, fa5[i], (i == 7) ? 8'hA5 : 8'h00,
                               i == 7, 1, 3'((i + 1) % 8), 0));

        foreach (tab_a[k]) step(tab_a[k], "frame4d");

        // Same frame with 3-cycle gaps; gap inputs are noise and must be ignored.
        for (int i = 0; i < 8; i++) begin
            step(mk(1, 1, i == 0, f4d[i], 8'h4D, i == 7, 1, 3'((i + 1) % 8), 0), "gap_beat");
            for (int g = 0; g < 3; g++)
                step(mk(1, 0, 1, 1, 8'h4D, 0, 1, 3'((i + 1) % 8), 0), "gap_hold");
        end

        foreach (tab_b[k]) step(tab_b[k], "seq");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/tdm_demux_rx.md
Name: tdm_demux_rx

Overview:
- Receive side of the team's time-division mux link. The transmit side scans N channels through an N:1 mux, one slot per valid beat, and marks slot 0 with sync.
- This block does the reverse. It tracks the slot with a counter, routes each sample through a 1:N demux into a shadow register, and publishes the whole frame in parallel when the frame completes.
- It sits between the serial link and the parallel consumer logic.

Parameters:
- N, 8, channels per frame (N >= 2).
- W, 1, bits per sample.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- valid_i  in  1  sample present on data_i this cycle.
- sync_i  in  1  marks slot 0. Only meaningful when valid_i=1.
- data_i  in  W  serial sample.
- ch_o  out  N*W  last complete frame. Slot i occupies bits [i*W +: W].
- frame_valid_o  out  1  one-cycle pulse: ch_o has just been updated.
- lock_o  out  1  1 while in LOCKED.
- slot_o  out  clog2(N)  next slot expected.
- err_o  out  1  one-cycle pulse on a framing error.

Behaviour:
- Reset: when rst_n=0 at a rising edge, all outputs and the shadow register clear to 0 and the state becomes HUNT. Applies mid-frame: any partial frame is discarded.
- Beat: any cycle with valid_i=0 is ignored. State, slot and outputs hold; the pulse outputs drop to 0.
- HUNT:
  - A beat with sync_i=0 is dropped. No error is raised.
  - A beat with sync_i=1: the sample goes to shadow[0], slot becomes 1, state becomes LOCKED.
- LOCKED, normal beat (sync_i=1 if and only if slot==0): the sample goes to shadow[slot].
  - If slot<N-1, slot increments.
  - If slot==N-1: at the same edge, ch_o <= {data_i, shadow[N-2:0]}, frame_valid_o=1 for one cycle, and slot wraps to 0.
  - Latency: ch_o and the pulse are visible the cycle after the last sample of the frame.
- LOCKED, early sync (sync_i=1 with slot!=0):
  - err_o pulses.
  - The partial frame is discarded and ch_o is unchanged.
  - The sample is taken as slot 0 and slot becomes 1. State stays LOCKED (resync).
- LOCKED, missing sync (slot==0, sync_i=0):
  - err_o pulses.
  - The sample is dropped and state returns to HUNT.
  - lock_o falls the next cycle.
- frame_valid_o and err_o are never asserted in the same cycle.
- Shadow slots not yet written in the current frame keep stale data. They are never published, because publishing requires all N slots.
- lock_o mirrors the state register. slot_o is 0 in HUNT.

Optional Feature:
- Macro: TDM_PARITY_EN.
- Enabled:
  - The frame carries an extra slot N holding the even parity (XOR) of all N*W data bits, placed in bit 0 of that sample.
  - The slot counter runs 0..N, and the publish and wrap happen on slot N.
  - Parity match: publish as above.
  - Parity mismatch: err_o pulses, ch_o is unchanged, slot wraps to 0 and state stays LOCKED.
- Disabled: N slots per frame and no parity check. The port list is identical in both builds.

Decomposition:
- Package tdm_pkg holds:
  - the state enum {HUNT, LOCKED};
  - the slot-width function/constant clog2(N+1);
  - the default N and W.
- The transmit block shares the same package.
- One sub-module, tdm_slot_counter: a wrapping counter with enable, synchronous clear and load-to-1 (resync), exposing count and a last-slot flag.
- The demux, shadow register and FSM remain in tdm_demux_rx.

Test Plan (N=8, W=1, TDM_PARITY_EN undefined unless noted):
- Reset then a clean frame with sync on slot 0, data 1,0,1,1,0,0,1,0 on slots 0..7 -> one cycle after slot 7, ch_o=8'h4D and frame_valid_o pulses once; lock_o=1 from the cycle after slot 0.
- Same frame with valid_i=0 gaps of 3 cycles between beats -> identical ch_o=8'h4D and a single pulse; slot_o holds during the gaps.
- Frame 8'hFF completed, then a second frame with sync re-asserted at slot 4 -> err_o pulses at that beat and ch_o stays 8'hFF; a full frame of 8'h0F from the resync point yields ch_o=8'h0F.
- After a good frame, slot 0 arrives without sync -> err_o pulse and lock_o=0; beats without sync are ignored; the next sync relocks.
- rst_n=0 for one edge at slot 5 -> every output is 0 the next cycle; the next frame 8'hA5 publishes correctly.
- TDM_PARITY_EN defined: 8'h4D followed by parity 0 -> publish 8'h4D. 8'h4D followed by parity 1 -> err_o pulses, ch_o is unchanged, and the next frame is accepted.
